dsram_ahb_arbiter: RTL and testbench

DSRAM_AHB_ARBITER -- requirements
Module: dsram_ahb_arbiter

---
 rtl/system_pkg.sv | 16 +
 rtl/ahb_req_hold.sv | 26 ++
 rtl/dsram_ahb_arbiter.sv | 120 ++++++++++++
 tb/tb_dsram_ahb_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/system_pkg.sv
// system_pkg: shared AHB transfer encodings, address-phase request struct and arbiter states.
package system_pkg;
  localparam int AHB_AW_MAX = 32;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  typedef struct packed {
    logic [AHB_AW_MAX-1:0] addr;
    logic [2:0]            size;
    logic                  write;
    logic [1:0]            trans;
  } ahb_req_t;
  localparam int AHB_REQ_W = $bits(ahb_req_t);
  typedef enum logic [1:0] {NORM, PEND0, PEND1} arb_state_t;
endpackage

// File: rtl/ahb_req_hold.sv
// ahb_req_hold: single-entry address-phase holding register with valid flag.
module ahb_req_hold
  import system_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_load,
  input  logic                 i_clr,
  input  logic [AHB_REQ_W-1:0] i_req,
  output logic [AHB_REQ_W-1:0] o_req,
  output logic                 o_valid
);
  logic [AHB_REQ_W-1:0] r_req;
  logic                 r_valid;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) r_req <= i_req;
      r_valid <= i_load | (r_valid & ~i_clr);
    end
  end
  assign o_req   = r_req;
  assign o_valid = r_valid;
endmodule

// File: rtl/dsram_ahb_arbiter.sv
// dsram_ahb_arbiter: two-master (core LSU, DMA) AHB arbiter in front of a zero-wait SRAM slave.
// A losing address phase is buffered and replayed next cycle; ADDR_W must not exceed 32.
module dsram_ahb_arbiter
  import system_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_hsel,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hwrite,
  input  logic [2:0]        m0_hsize,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic [DATA_W-1:0] m0_hrdata,
  output logic              m0_hresp,
  input  logic              m1_hsel,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hwrite,
  input  logic [2:0]        m1_hsize,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic              m1_hresp,
  output logic              s_hsel,
  output logic [ADDR_W-1:0] s_haddr,
  output logic [1:0]        s_htrans,
  output logic              s_hwrite,
  output logic [2:0]        s_hsize,
  output logic [DATA_W-1:0] s_hwdata,
  input  logic              s_hready,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hresp
);
  arb_state_t r_state, w_state_n;
  logic       r_ptr, w_ptr_n, r_own, r_own_v;
  logic       w_stall0, w_stall1, w_live0, w_live1;
  logic       w_gnt_v, w_gnt_id, w_cap, w_cap_id, w_hold_v;
  ahb_req_t   w_req0, w_req1, w_hold, w_gnt, w_cap_req;

  assign w_req0 = '{addr: AHB_AW_MAX'(m0_haddr), size: m0_hsize, write: m0_hwrite, trans: m0_htrans};
  assign w_req1 = '{addr: AHB_AW_MAX'(m1_haddr), size: m1_hsize, write: m1_hwrite, trans: m1_htrans};

  // A master is stalled only while its buffered address phase waits to be replayed
  assign w_stall0  = (r_state == PEND0);
  assign w_stall1  = (r_state == PEND1);
  assign m0_hready = ~w_stall0 & s_hready;
  assign m1_hready = ~w_stall1 & s_hready;
  assign w_live0   = m0_hsel & m0_htrans[1] & m0_hready;
  assign w_live1   = m1_hsel & m1_htrans[1] & m1_hready;

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_gnt_v   = 1'b0;
    w_gnt_id  = 1'b0;
    w_cap     = 1'b0;
    w_cap_id  = 1'b0;
    if (w_hold_v) begin
      w_gnt_v  = 1'b1;
      w_gnt_id = (r_state == PEND1);
      w_cap    = w_gnt_id ? w_live0 : w_live1;
      w_cap_id = ~w_gnt_id;
    end else if (w_live0 & w_live1) begin
      w_gnt_v  = 1'b1;
      w_gnt_id = r_ptr;
      w_cap    = 1'b1;
      w_cap_id = ~r_ptr;
      w_ptr_n  = s_hready ? ~r_ptr : r_ptr;
    end else begin
      w_gnt_v  = w_live0 | w_live1;
      w_gnt_id = w_live1;
    end
    if (s_hready) w_state_n = w_cap ? (w_cap_id ? PEND1 : PEND0) : NORM;
  end

  assign w_cap_req = w_cap_id ? w_req1 : w_req0;
  assign w_gnt     = w_hold_v ? w_hold : (w_gnt_id ? w_req1 : w_req0);

  ahb_req_hold u_hold (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_cap & s_hready),
    .i_clr   (s_hready),
    .i_req   (w_cap_req),
    .o_req   (w_hold),
    .o_valid (w_hold_v)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= NORM;
      r_ptr   <= 1'b0;
      r_own   <= 1'b0;
      r_own_v <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      if (s_hready) begin
        r_own_v <= w_gnt_v;
        r_own   <= w_gnt_id;
      end
    end
  end

  assign s_hsel    = w_gnt_v;
  assign s_haddr   = ADDR_W'(w_gnt.addr);
  assign s_htrans  = w_gnt_v ? w_gnt.trans : HTRANS_IDLE;
  assign s_hwrite  = w_gnt_v & w_gnt.write;
  assign s_hsize   = w_gnt.size;
  assign s_hwdata  = r_own ? m1_hwdata : m0_hwdata;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign m0_hresp  = r_own_v & ~r_own & ~w_stall0 & s_hresp;
  assign m1_hresp  = r_own_v & r_own & ~w_stall1 & s_hresp;
endmodule

// File: tb/tb_dsram_ahb_arbiter.sv
// tb_dsram_ahb_arbiter: directed checks of grant order, replay stall, data routing, freeze and reset.
module tb_dsram_ahb_arbiter;
  localparam int AW = 28;
  localparam int DW = 32;
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          m0_hsel, m0_hwrite, m0_hready, m0_hresp;
  logic [AW-1:0] m0_haddr;
  logic [1:0]    m0_htrans;
  logic [2:0]    m0_hsize;
  logic [DW-1:0] m0_hwdata, m0_hrdata;
  logic          m1_hsel, m1_hwrite, m1_hready, m1_hresp;
  logic [AW-1:0] m1_haddr;
  logic [1:0]    m1_htrans;
  logic [2:0]    m1_hsize;
  logic [DW-1:0] m1_hwdata, m1_hrdata;
  logic          s_hsel, s_hwrite, s_hready, s_hresp;
  logic [AW-1:0] s_haddr;
  logic [1:0]    s_htrans;
  logic [2:0]    s_hsize;
  logic [DW-1:0] s_hwdata, s_hrdata;
  int total = 0;
  int bad = 0;

  logic [1:0]    t4_tr0 [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
  logic [AW-1:0] t4_a0  [6] = '{28'h400, 28'h404, 28'h408, 28'h408, 28'h0, 28'h0};
  logic [1:0]    t4_tr1 [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
  logic [AW-1:0] t4_a1  [6] = '{28'h500, 28'h504, 28'h504, 28'h508, 28'h508, 28'h0};
  logic [AW-1:0] t4_exp [6] = '{28'h400, 28'h500, 28'h404, 28'h504, 28'h408, 28'h508};
  logic          t4_r0  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic          t4_r1  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  dsram_ahb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn),
    .m0_hsel(m0_hsel), .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
    .m0_hsize(m0_hsize), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hrdata(m0_hrdata),
    .m0_hresp(m0_hresp),
    .m1_hsel(m1_hsel), .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
    .m1_hsize(m1_hsize), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hrdata(m1_hrdata),
    .m1_hresp(m1_hresp),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hrdata(s_hrdata),
    .s_hresp(s_hresp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic [1:0] tr, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    m0_hsel = 1'b1; m0_htrans = tr; m0_hwrite = wr; m0_haddr = a; m0_hsize = 3'd2; m0_hwdata = wd;
  endtask

  task automatic drv1(input logic [1:0] tr, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    m1_hsel = 1'b1; m1_htrans = tr; m1_hwrite = wr; m1_haddr = a; m1_hsize = 3'd2; m1_hwdata = wd;
  endtask

  initial begin
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
    drv0(2'b00, 1'b0, '0, '0);
    drv1(2'b00, 1'b0, '0, '0);
    #2;
    chk("rst_hsel", s_hsel, 0);
    chk("rst_htrans", s_htrans, 0);
    chk("rst_m0_rdy", m0_hready, 1);
    chk("rst_m1_rdy", m1_hready, 1);
    chk("rst_m0_resp", m0_hresp, 0);
    chk("rst_m1_resp", m1_hresp, 0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    // single m0 read goes straight through
    drv0(2'b10, 1'b0, 28'h100, '0); #1;
    chk("t1_haddr", s_haddr, 28'h100);
    chk("t1_htrans", s_htrans, 2'b10);
    chk("t1_hwrite", s_hwrite, 0);
    chk("t1_m0_rdy", m0_hready, 1);
    chk("t1_m1_rdy", m1_hready, 1);
    @(negedge clk);
    drv0(2'b00, 1'b0, '0, '0); s_hrdata = 32'hAAAA0001; s_hresp = 1'b1; #1;
    chk("t1_rdata", m0_hrdata, 32'hAAAA0001);
    chk("t1_m0_resp", m0_hresp, 1);
    chk("t1_m1_resp", m1_hresp, 0);
    chk("t1_m0_rdy_dp", m0_hready, 1);
    chk("t1_idle_hsel", s_hsel, 0);
    // first collision: pointer at m0
    @(negedge clk);
    s_hresp = 1'b0;
    drv0(2'b10, 1'b1, 28'h200, '0); drv1(2'b10, 1'b1, 28'h300, '0); #1;
    chk("t2_haddr_a", s_haddr, 28'h200);
    chk("t2_hwrite", s_hwrite, 1);
    chk("t2_m1_rdy_a", m1_hready, 1);
    @(negedge clk);
    drv0(2'b00, 1'b0, '0, 32'hD0); drv1(2'b00, 1'b0, '0, 32'hD1); #1;
    chk("t2_haddr_b", s_haddr, 28'h300);
    chk("t2_htrans_b", s_htrans, 2'b10);
    chk("t2_m1_rdy_b", m1_hready, 0);
    chk("t2_m0_rdy_b", m0_hready, 1);
    chk("t2_wdata_m0", s_hwdata, 32'hD0);
    @(negedge clk);
    drv0(2'b00, 1'b0, '0, 32'hE0); drv1(2'b00, 1'b0, '0, 32'hD1); #1;
    chk("t2_wdata_m1", s_hwdata, 32'hD1);
    chk("t2_m1_rdy_c", m1_hready, 1);
    chk("t2_idle", s_htrans, 0);
    // second collision: pointer flipped to m1
    @(negedge clk);
    drv0(2'b10, 1'b1, 28'h204, '0); drv1(2'b10, 1'b1, 28'h304, '0); #1;
    chk("t3_haddr_a", s_haddr, 28'h304);
    chk("t3_m0_rdy_a", m0_hready, 1);
    @(negedge clk);
    drv0(2'b00, 1'b0, '0, 32'hE4); drv1(2'b00, 1'b0, '0, 32'hF4); #1;
    chk("t3_haddr_b", s_haddr, 28'h204);
    chk("t3_m0_rdy_b", m0_hready, 0);
    chk("t3_m1_rdy_b", m1_hready, 1);
    chk("t3_wdata_m1", s_hwdata, 32'hF4);
    @(negedge clk);
    drv0(2'b00, 1'b0, '0, 32'hE4); drv1(2'b00, 1'b0, '0, 32'h55); #1;
    chk("t3_wdata_m0", s_hwdata, 32'hE4);
    chk("t3_m0_rdy_c", m0_hready, 1);
    // back-to-back collisions alternate and lose nothing
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drv0(t4_tr0[i], 1'b0, t4_a0[i], '0); drv1(t4_tr1[i], 1'b0, t4_a1[i], '0); #1;
      chk($sformatf("t4_haddr_%0d", i), s_haddr, t4_exp[i]);
      chk($sformatf("t4_htrans_%0d", i), s_htrans, 2'b10);
      chk($sformatf("t4_m0_rdy_%0d", i), m0_hready, t4_r0[i]);
      chk($sformatf("t4_m1_rdy_%0d", i), m1_hready, t4_r1[i]);
    end
    @(negedge clk);
    drv0(2'b00, 1'b0, '0, '0); drv1(2'b00, 1'b0, '0, '0); #1;
    chk("t4_idle", s_htrans, 0);
    chk("t4_m0_rdy_end", m0_hready, 1);
    chk("t4_m1_rdy_end", m1_hready, 1);
    // slave wait states freeze state and pointer (pointer at m1 here)
    @(negedge clk);
    drv0(2'b10, 1'b1, 28'h600, '0); drv1(2'b10, 1'b1, 28'h700, '0); #1;
    chk("t5_haddr_a", s_haddr, 28'h700);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drv0(2'b00, 1'b0, '0, '0); drv1(2'b00, 1'b0, '0, '0); s_hready = 1'b0; #1;
      chk($sformatf("t5_haddr_w%0d", i), s_haddr, 28'h600);
      chk($sformatf("t5_htrans_w%0d", i), s_htrans, 2'b10);
      chk($sformatf("t5_m0_rdy_w%0d", i), m0_hready, 0);
      chk($sformatf("t5_m1_rdy_w%0d", i), m1_hready, 0);
    end
    @(negedge clk);
    s_hready = 1'b1; #1;
    chk("t5_haddr_go", s_haddr, 28'h600);
    chk("t5_m0_rdy_go", m0_hready, 0);
    chk("t5_m1_rdy_go", m1_hready, 1);
    @(negedge clk); #1;
    chk("t5_idle", s_htrans, 0);
    chk("t5_m0_rdy_end", m0_hready, 1);
    @(negedge clk);
    drv0(2'b10, 1'b1, 28'h604, '0); drv1(2'b10, 1'b1, 28'h704, '0); #1;
    chk("t5_ptr_kept", s_haddr, 28'h604);
    // reset asserted while m1 is pending
    @(negedge clk);
    drv0(2'b00, 1'b0, '0, '0); drv1(2'b00, 1'b0, '0, '0); #1;
    chk("t6_pend_haddr", s_haddr, 28'h704);
    chk("t6_pend_m1_rdy", m1_hready, 0);
    #1 rstn = 1'b0;
    s_hresp = 1'b1; #1;
    chk("t6_rst_m1_rdy", m1_hready, 1);
    chk("t6_rst_htrans", s_htrans, 0);
    chk("t6_rst_hsel", s_hsel, 0);
    chk("t6_rst_m0_resp", m0_hresp, 0);
    chk("t6_rst_m1_resp", m1_hresp, 0);
    s_hresp = 1'b0;
    @(negedge clk);
    rstn = 1'b1; #1;
    chk("t6_rel_htrans", s_htrans, 0);
    chk("t6_rel_hwrite", s_hwrite, 0);
    @(negedge clk); #1;
    chk("t6_rel_hsel", s_hsel, 0);
    @(negedge clk);
    drv0(2'b10, 1'b0, 28'h800, '0); drv1(2'b10, 1'b0, 28'h900, '0); #1;
    chk("t6_ptr_reset", s_haddr, 28'h800);
    @(negedge clk);
    drv0(2'b00, 1'b0, '0, '0); drv1(2'b00, 1'b0, '0, '0); #1;
    chk("t6_replay", s_haddr, 28'h900);
    chk("t6_replay_rdy", m1_hready, 0);
    @(negedge clk); #1;
    chk("t6_end_idle", s_htrans, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
